// File: rtl/fp_sumsq_accum_pkg.sv
// Shared definitions for the fp_* fixed-point family: FSM encodings and a
// constant-safe ceil(log2) used to size counters and accumulators.
package fp_sumsq_accum_pkg;

  localparam logic [1:0] ST_ACC   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic int fp_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(n)) begin
        r = r + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fp_square_stage.sv
// Squaring stage: two's-complement magnitude, unsigned square, registered
// product with a one-cycle valid flag.
module fp_square_stage
  import fp_sumsq_accum_pkg::*;
#(
  parameter int WL = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CE,
  input  logic            accept,
  input  logic [WL-1:0]   din,
  output logic [2*WL-2:0] p,
  output logic            p_vld
);

  localparam int PW = 2 * WL - 1;

  logic [WL-1:0] mag;
  logic [PW-1:0] p_d, p_q;
  logic          p_vld_d, p_vld_q;

  // The most negative input has magnitude 2^(WL-1), which still fits unsigned
  // in WL bits, and its square 2^(2WL-2) fits in PW bits.
  always_comb begin
    mag     = din[WL-1] ? (~din + WL'(1)) : din;
    p_d     = accept ? (PW'(mag) * PW'(mag)) : p_q;
    p_vld_d = accept;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p_q     <= '0;
      p_vld_q <= 1'b0;
    end else if (CE) begin
      p_q     <= p_d;
      p_vld_q <= p_vld_d;
    end
  end

  assign p     = p_q;
  assign p_vld = p_vld_q;

endmodule

// File: rtl/fp_sumsq_accum.sv
// Sum-of-squares accumulator: squares N_ELEM signed WI.WF components and
// emits a saturated, non-negative WI.WF ||v||^2 with a valid/ready handshake.
module fp_sumsq_accum
  import fp_sumsq_accum_pkg::*;
#(
  parameter int WI     = 4,
  parameter int WF     = 4,
  parameter int N_ELEM = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic [WI+WF-1:0] din,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WI+WF-1:0] dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sat,
  output logic             out_zero
);

  localparam int WL = WI + WF;
  localparam int PW = 2 * WL - 1;
  localparam int AW = PW + fp_clog2(N_ELEM);
  localparam int RW = AW - WF;
  localparam int CW = (N_ELEM > 1) ? fp_clog2(N_ELEM) : 1;
  localparam logic [WL-1:0] MAX_POS  = {1'b0, {(WL-1){1'b1}}};
  localparam logic [CW-1:0] LAST_IDX = CW'(N_ELEM - 1);

  logic [1:0]    state_d, state_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic [AW-1:0] acc_d, acc_q;
  logic [WL-1:0] dout_d, dout_q;
  logic          out_valid_d, out_valid_q;
  logic          out_sat_d, out_sat_q;
  logic          out_zero_d, out_zero_q;

  logic          accept;
  logic [PW-1:0] p;
  logic          p_vld;
  logic [AW-1:0] sum;
  logic [RW-1:0] r;
  logic          r_sat;
  logic [WL-1:0] r_dout;

  assign in_ready = (state_q == ST_ACC) && CE;
  assign accept   = in_valid && in_ready;

  fp_square_stage #(.WL(WL)) u_square (
    .CLK   (CLK),
    .RST   (RST),
    .CE    (CE),
    .accept(accept),
    .din   (din),
    .p     (p),
    .p_vld (p_vld)
  );

  always_comb begin
    sum    = p_vld ? (acc_q + AW'(p)) : acc_q;
    r      = sum[AW-1:WF];
    r_sat  = (r > RW'(MAX_POS));
    r_dout = r_sat ? MAX_POS : r[WL-1:0];

    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    out_sat_d   = out_sat_q;
    out_zero_d  = out_zero_q;

    case (state_q)
      ST_ACC: begin
        // The product of the previous accept lands here while the next is squared.
        acc_d = sum;
        if (accept) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_DRAIN: begin
        acc_d       = sum;
        dout_d      = r_dout;
        out_sat_d   = r_sat;
        out_zero_d  = (r_dout == '0);
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          state_d     = ST_ACC;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase
  end

  // CE low freezes every register, so a stalled cycle neither accepts nor drains.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_ACC;
      cnt_q       <= '0;
      acc_q       <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
      out_zero_q  <= 1'b0;
    end else if (CE) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      out_sat_q   <= out_sat_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign dout      = dout_q;
  assign out_valid = out_valid_q;
  assign out_sat   = out_sat_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_fp_sumsq_accum.sv
// Self-checking bench for fp_sumsq_accum (WI=4, WF=4, N_ELEM=3) with a
// reference model feeding an expected-result queue.
module tb_fp_sumsq_accum;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CE = 1'b1;
  logic [7:0] din = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] dout;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_sat;
  logic       out_zero;

  int checks = 0;
  int failures = 0;
  logic ce_toggle = 1'b0;
  logic [9:0] exp_q[$];

  fp_sumsq_accum #(.WI(4), .WF(4), .N_ELEM(3)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .din(din), .in_valid(in_valid),
    .in_ready(in_ready), .dout(dout), .out_valid(out_valid),
    .out_ready(out_ready), .out_sat(out_sat), .out_zero(out_zero)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer sum of squares in 2^-8 units, truncated to 2^-4, clipped at 127.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    int s, r;
    logic [7:0] d;
    s = $signed(a) * $signed(a) + $signed(b) * $signed(b) + $signed(c) * $signed(c);
    r = s >> 4;
    d = (r > 127) ? 8'h7F : r[7:0];
    return {(r > 127), (d == 8'h00), d};
  endfunction

  task automatic send_elem(input logic [7:0] e);
    int n;
    n = 0;
    din = e;
    in_valid = 1'b1;
    forever begin
      @(negedge CLK);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        check_eq("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    exp_q.push_back(model(a, b, c));
    send_elem(a);
    send_elem(b);
    send_elem(c);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge CLK);
      n++;
    end
    check_eq("idle_queue", exp_q.size(), 32'd0);
    @(posedge CLK);
    #1;
  endtask

  // CE is either held high or toggled every cycle, changing just after the edge.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      CE = ce_toggle ? ~CE : 1'b1;
    end
  end

  // Output monitor: compares each completed output handshake against the queue head.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge CLK);
      if (!RST && out_valid && out_ready && CE) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("dout", dout, e[7:0]);
          check_eq("out_sat", out_sat, e[9]);
          check_eq("out_zero", out_zero, e[8]);
        end
      end
    end
  end

  initial begin
    #1;
    check_eq("rst_dout", dout, 8'h00);
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_sat", out_sat, 1'b0);
    check_eq("rst_zero", out_zero, 1'b0);
    #22;
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Basic vector and latency: DRAIN cycle, then out_valid.
    send_vec(8'h10, 8'hF0, 8'h08);
    @(negedge CLK);
    check_eq("lat_drain", out_valid, 1'b0);
    @(negedge CLK);
    check_eq("lat_valid", out_valid, 1'b1);
    check_eq("t1_dout", dout, 8'h24);
    wait_idle();

    // Saturation and zero cases, back to back.
    send_vec(8'h40, 8'h40, 8'h40);
    send_vec(8'h80, 8'h00, 8'h00);
    send_vec(8'h00, 8'h00, 8'h00);
    send_vec(8'h01, 8'h01, 8'h01);
    send_vec(8'hE8, 8'h13, 8'h07);
    wait_idle();

    // Backpressure with in_valid held high.
    out_ready = 1'b0;
    send_vec(8'h10, 8'h10, 8'h10);
    din = 8'h10;
    in_valid = 1'b1;
    @(negedge CLK);
    check_eq("bp_drain_ready", in_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check_eq("bp_valid", out_valid, 1'b1);
      check_eq("bp_dout", dout, 8'h30);
      check_eq("bp_ready", in_ready, 1'b0);
    end
    @(posedge CLK);
    #1;
    out_ready = 1'b1;
    send_vec(8'h10, 8'h10, 8'h10);
    wait_idle();

    // Asynchronous reset mid-vector discards the partial sum.
    send_elem(8'h20);
    send_elem(8'h20);
    #3;
    RST = 1'b1;
    #1;
    check_eq("arst_dout", dout, 8'h00);
    check_eq("arst_valid", out_valid, 1'b0);
    #2;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    send_vec(8'h10, 8'h10, 8'h10);
    wait_idle();

    // CE toggling every cycle with in_valid high.
    ce_toggle = 1'b1;
    send_vec(8'h18, 8'h18, 8'h18);
    din = 8'h18;
    in_valid = 1'b1;
    wait_idle();
    in_valid = 1'b0;
    ce_toggle = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    check_eq("ce_no_extra", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
